// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory, redirect and decode handshake bundle for fetch_queue (master = fetch side, slave = memory/decode side)
interface fetch_queue_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc_inc;
  logic        instr_ready;
  logic        halted;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc_inc, halted,
    input  imem_ack, imem_data, redirect, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc_inc, halted,
    output imem_ack, imem_data, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry instruction fetch queue; ports clk, rst (async, active-high), bus (fetch_queue_if.master); define FETCH_HALT_DETECT_EN to stop fetch after a HALT word
module fetch_queue #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.master bus
);
  typedef enum logic [1:0] {RUN, DISCARD, HALTED} state_t;
  state_t      state, state_n;
  logic [15:0] pc, held_addr, pc_inc;
  logic [31:0] ent [2];
  logic        rd;
  logic [1:0]  count;
  logic        push, pop, is_halt;
  assign pc_inc = pc + 16'd2;
  // a request raised in RUN cannot be withdrawn: count only grows on ack, and redirect moves to DISCARD
  assign bus.imem_req = ~rst & ((state == DISCARD) | ((state == RUN) & (count != 2'd2)));
  assign bus.imem_addr = (state == DISCARD) ? held_addr : pc;
  assign bus.instr_valid = count != 2'd0;
  assign {bus.instr, bus.instr_pc_inc} = ent[rd];
  assign push = (state == RUN) & bus.imem_req & bus.imem_ack & ~bus.redirect;
  assign pop = bus.instr_valid & bus.instr_ready & ~bus.redirect;
`ifdef FETCH_HALT_DETECT_EN
  assign is_halt = bus.imem_data[15:11] == 5'b00000;
  assign bus.halted = state == HALTED;
`else
  assign is_halt = 1'b0;
  assign bus.halted = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      RUN:     state_n = bus.redirect ? ((bus.imem_req & ~bus.imem_ack) ? DISCARD : RUN)
                                      : ((push & is_halt) ? HALTED : RUN);
      DISCARD: state_n = bus.imem_ack ? RUN : DISCARD;
      HALTED:  state_n = bus.redirect ? RUN : HALTED;
      default: state_n = RUN;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc        <= RESET_PC;
      held_addr <= RESET_PC;
      count     <= 2'd0;
      rd        <= 1'b0;
      ent[0]    <= 32'd0;
      ent[1]    <= 32'd0;
    end else begin
      pc <= bus.redirect ? bus.redirect_pc : (push ? pc_inc : pc);
      // the address of a request abandoned by redirect must stay on the bus until its ack
      if (state == RUN) held_addr <= pc;
      count <= bus.redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
      // push never happens at count 2, so the tail slot is rd + count[0]
      if (push) ent[rd ^ count[0]] <= {bus.imem_data, pc_inc};
      if (pop) rd <= ~rd;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC loaded on reset.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  16  byte address of the requested instruction.
REQ-006 imem_ack  input  1  read complete; imem_data valid this cycle; may assert in the same cycle as imem_req.
REQ-007 imem_data  input  16  instruction word returned.
REQ-008 redirect  input  1  branch/jump resolved taken; flush and refetch.
REQ-009 redirect_pc  input  16  target PC, sampled when redirect=1.
REQ-010 instr_valid  output  1  queue head holds an instruction for decode.
REQ-011 instr  output  16  head instruction word, consumed by decode.
REQ-012 instr_pc_inc  output  16  head instruction's PC+2.
REQ-013 instr_ready  input  1  decode accepts the head this cycle (low = stall).
REQ-014 halted  output  1  fetch stopped on a HALT.

Function
REQ-015 Queue: 2-entry FIFO of {instr, pc_inc}; instr_valid = (count != 0); instr and instr_pc_inc driven from head.
REQ-016 Pop: on the rising edge where instr_valid && instr_ready.
REQ-017 Push: on the rising edge where imem_req && imem_ack in state RUN; entry = {imem_data, PC+2}.
REQ-018 PC advances by 2 on each push; PC+2 wraps 16'hFFFE -> 16'h0000.
REQ-019 A new request starts only in RUN with count < 2; imem_addr = PC.
REQ-020 Once raised, imem_req and imem_addr are held stable until imem_ack, regardless of count or redirect.
REQ-021 At most one request is outstanding; with a same-cycle ack, throughput is one instruction per cycle.
REQ-022 States are RUN, DISCARD and HALTED.
REQ-023 Transition RUN->DISCARD: redirect=1 while imem_req=1 and imem_ack=0; held request completes, response dropped.
REQ-024 Transition DISCARD->RUN: on imem_ack; no push.
REQ-025 Transition RUN->HALTED: on pushing a HALT word (imem_data[15:11]==5'b00000), when FETCH_HALT_DETECT_EN is defined.
REQ-026 Transition HALTED->RUN: on redirect=1.
REQ-027 HALTED: imem_req=0, halted=1; queued entries, including the HALT itself, still drain to decode.
REQ-028 Redirect, any state: queue flushed (count=0) and PC <= redirect_pc on that edge; redirect overrides a simultaneous pop.
REQ-029 Redirect in the same cycle as imem_ack: response discarded, no push, next state RUN.
REQ-030 Redirect while in DISCARD: PC updated to the newest redirect_pc; state stays DISCARD.
REQ-031 Full queue (count==2): no new request; push while full cannot occur, given REQ-019.
REQ-032 Empty queue: instr_valid=0; instr and instr_pc_inc hold their last values (don't-care).
REQ-033 Simultaneous push and pop at count 1: count stays 1 and the new entry becomes head.

Reset
REQ-034 On rst=1 asynchronously: PC=RESET_PC, count=0, state RUN, imem_req=0, instr_valid=0, halted=0, instr=16'h0000, instr_pc_inc=16'h0000.
REQ-035 Reset mid-request abandons the request; the first request after reset release targets RESET_PC.

Configuration
REQ-036 Macro FETCH_HALT_DETECT_EN defined: REQ-025 applies; fetch stops after pushing a HALT word.
REQ-037 Macro FETCH_HALT_DETECT_EN undefined: HALT words are ordinary instructions; halted is tied 0 and HALTED is unreachable.

Verification
REQ-038 Reset, imem_ack tied 1, instr_ready=1, memory returns 16'hC000+addr -> one instr per cycle, instr_pc_inc = 2, 4, 6, ...
REQ-039 instr_ready=0 for 5 cycles -> count saturates at 2, imem_req=0, head unchanged; ready=1 -> drain resumes in order.
REQ-040 imem_ack delayed 3 cycles, redirect to 16'h0100 during the wait -> addr held until ack, response dropped, next request addr 16'h0100, no stale instr delivered.
REQ-041 HALT word 16'h0000 at addr 16'h0004 (macro defined) -> 16'h0004 delivered, halted=1, imem_req stays 0; redirect to 16'h0010 -> fetch resumes at 16'h0010.
REQ-042 Same stimulus with macro undefined -> fetch continues to 16'h0006, halted=0; async rst pulse mid-request -> outputs at reset values immediately, next addr = RESET_PC.
